// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_bridge
// Purpose  : Sequencer between spi_slave and the internal register bus.
//            Turns one SPI frame (address + payload) into exactly one bus
//            read or write using a req/ack handshake.
//            - Read frame : bus read is issued as soon as the address is in,
//                           the returned data is loaded into the slave's
//                           transmit shifter before the payload phase.
//            - Write frame: bus write is issued once the payload has arrived.
// Optional : SPI_BUS_TIMEOUT_EN - bounds the wait for bus_ack to
//            TIMEOUT_CYCLES; a timed-out read returns RD_ERR_VAL and a
//            timed-out write is dropped. Both set the sticky err flag.
//            Without the macro requests wait for ack forever and err is 0.
// Ports    : clk, reset_i (async, active low)
//            spi_reg_addr/spi_addr_dv/spi_rw/spi_rx_d/spi_rxdv  <- spi_slave
//            spi_tx_d/spi_tx_en                                  -> spi_slave
//            bus_addr/bus_wdata/bus_we/bus_re -> bus, bus_rdata/bus_ack <- bus
//            busy (not idle), err (sticky timeout), err_clr (clears err)
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bridge #(
  parameter int                 ADDRSZ         = 7,
  parameter int                 PAYLOAD        = 8,
  parameter int                 TXEN_HOLD      = 2,
  parameter int                 TIMEOUT_CYCLES = 64,
  parameter logic [PAYLOAD-1:0] RD_ERR_VAL     = 8'hEE
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic [ADDRSZ-1:0]  spi_reg_addr,
  input  logic               spi_addr_dv,
  input  logic               spi_rw,
  input  logic [PAYLOAD-1:0] spi_rx_d,
  input  logic               spi_rxdv,
  output logic [PAYLOAD-1:0] spi_tx_d,
  output logic               spi_tx_en,
  output logic [ADDRSZ-1:0]  bus_addr,
  output logic [PAYLOAD-1:0] bus_wdata,
  output logic               bus_we,
  output logic               bus_re,
  input  logic [PAYLOAD-1:0] bus_rdata,
  input  logic               bus_ack,
  output logic               busy,
  output logic               err,
  input  logic               err_clr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_LOAD = 3'd2,
    WR_WAIT = 3'd3,
    WR_REQ  = 3'd4
  } state_t;

  // tx_en hold counter: counts 0 .. TXEN_HOLD-1 while in RD_LOAD
  localparam int                HOLD_W      = (TXEN_HOLD > 1) ? $clog2(TXEN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(TXEN_HOLD - 1);

  state_t               r_state,     w_state;
  logic [ADDRSZ-1:0]    r_bus_addr,  w_bus_addr;
  logic [PAYLOAD-1:0]   r_bus_wdata, w_bus_wdata;
  logic                 r_bus_we,    w_bus_we;
  logic                 r_bus_re,    w_bus_re;
  logic [PAYLOAD-1:0]   r_tx_d,      w_tx_d;
  logic                 r_tx_en,     w_tx_en;
  logic [HOLD_W-1:0]    r_hold_cnt,  w_hold_cnt;
  logic                 r_rxdv_d;
  logic                 w_rxdv_rise;
  logic                 w_timeout;
  logic                 w_err_set;

  assign w_rxdv_rise = spi_rxdv & ~r_rxdv_d;

`ifdef SPI_BUS_TIMEOUT_EN
  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;

  // r_to_cnt holds the number of completed wait cycles; the request is
  // dropped at the end of the TIMEOUT_CYCLES-th cycle unless ack arrives
  // in that same cycle (ack wins).
  assign w_timeout = (r_to_cnt == c_to_last) & ~bus_ack;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == RD_REQ || r_state == WR_REQ)
        r_to_cnt <= r_to_cnt + 1'b1;
      else
        r_to_cnt <= '0;
      // a new timeout beats a simultaneous clear
      if (w_err_set)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign err          = 1'b0;
  assign w_unused_cfg = err_clr | w_err_set | (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    w_state     = r_state;
    w_bus_addr  = r_bus_addr;
    w_bus_wdata = r_bus_wdata;
    w_bus_we    = r_bus_we;
    w_bus_re    = r_bus_re;
    w_tx_d      = r_tx_d;
    w_tx_en     = r_tx_en;
    w_hold_cnt  = '0;
    w_err_set   = 1'b0;

    case (r_state)
      // A new address in WR_WAIT means the previous frame was aborted:
      // the pending write is discarded and the new frame is decoded as
      // if we were idle.
      IDLE, WR_WAIT: begin
        if (spi_addr_dv) begin
          w_bus_addr = spi_reg_addr;
          if (!spi_rw) begin
            w_bus_re = 1'b1;
            w_state  = RD_REQ;
          end else begin
            w_state  = WR_WAIT;
          end
        end else if (r_state == WR_WAIT && w_rxdv_rise) begin
          w_bus_wdata = spi_rx_d;
          w_bus_we    = 1'b1;
          w_state     = WR_REQ;
        end
      end

      RD_REQ: begin
        if (bus_ack) begin
          w_tx_d   = bus_rdata;
          w_bus_re = 1'b0;
          w_tx_en  = 1'b1;
          w_state  = RD_LOAD;
        end else if (w_timeout) begin
          w_tx_d    = RD_ERR_VAL;
          w_bus_re  = 1'b0;
          w_tx_en   = 1'b1;
          w_err_set = 1'b1;
          w_state   = RD_LOAD;
        end
      end

      // tx_en must stay high long enough for the slave's synchroniser
      RD_LOAD: begin
        if (r_hold_cnt == c_hold_last) begin
          w_tx_en = 1'b0;
          w_state = IDLE;
        end else begin
          w_hold_cnt = r_hold_cnt + 1'b1;
        end
      end

      WR_REQ: begin
        if (bus_ack) begin
          w_bus_we = 1'b0;
          w_state  = IDLE;
        end else if (w_timeout) begin
          w_bus_we  = 1'b0;
          w_err_set = 1'b1;
          w_state   = IDLE;
        end
      end

      default: begin
        w_bus_we = 1'b0;
        w_bus_re = 1'b0;
        w_tx_en  = 1'b0;
        w_state  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      r_state     <= IDLE;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_we    <= 1'b0;
      r_bus_re    <= 1'b0;
      r_tx_d      <= '0;
      r_tx_en     <= 1'b0;
      r_hold_cnt  <= '0;
      r_rxdv_d    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
      r_bus_we    <= w_bus_we;
      r_bus_re    <= w_bus_re;
      r_tx_d      <= w_tx_d;
      r_tx_en     <= w_tx_en;
      r_hold_cnt  <= w_hold_cnt;
      r_rxdv_d    <= spi_rxdv;
    end
  end

  assign spi_tx_d  = r_tx_d;
  assign spi_tx_en = r_tx_en;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_we    = r_bus_we;
  assign bus_re    = r_bus_re;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_bridge
// Purpose  : Directed self-checking bench for spi_reg_bridge. Inputs change
//            1 time unit after the rising edge; outputs are observed there.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [6:0] spi_reg_addr;
  logic       spi_addr_dv;
  logic       spi_rw;
  logic [7:0] spi_rx_d;
  logic       spi_rxdv;
  logic [7:0] spi_tx_d;
  logic       spi_tx_en;
  logic [6:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       bus_ack;
  logic       busy;
  logic       err;
  logic       err_clr;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  spi_reg_bridge dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .spi_reg_addr (spi_reg_addr),
    .spi_addr_dv  (spi_addr_dv),
    .spi_rw       (spi_rw),
    .spi_rx_d     (spi_rx_d),
    .spi_rxdv     (spi_rxdv),
    .spi_tx_d     (spi_tx_d),
    .spi_tx_en    (spi_tx_en),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_we       (bus_we),
    .bus_re       (bus_re),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .busy         (busy),
    .err          (err),
    .err_clr      (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; spi_reg_addr = '0; spi_addr_dv = 1'b0; spi_rw = 1'b0;
    spi_rx_d = '0; spi_rxdv = 1'b0; bus_rdata = '0; bus_ack = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({spi_tx_d, spi_tx_en, bus_addr, bus_wdata, bus_we, bus_re, busy, err} !== 28'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h exp 0", {spi_tx_d, spi_tx_en, bus_addr, bus_wdata, bus_we, bus_re, busy, err});
    end
    reset_i = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int n_re;
    int n_en;
    spi_addr_dv = 1'b1; spi_rw = 1'b0; spi_reg_addr = 7'h15;
    tick();
    spi_addr_dv = 1'b0;
    vectors++;
    if (bus_re !== 1'b1 || bus_addr !== 7'h15 || busy !== 1'b1 || bus_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_req: got re=%b addr=%h busy=%b we=%b exp re=1 addr=15 busy=1 we=0", bus_re, bus_addr, busy, bus_we);
    end
    n_re = 0;
    for (int i = 0; i < 10 && bus_re; i++) begin
      n_re++;
      if (n_re == 3) begin bus_ack = 1'b1; bus_rdata = 8'hA5; end
      tick();
      bus_ack = 1'b0; bus_rdata = 8'h00;
    end
    vectors++;
    if (n_re != 3) begin
      miscompares++;
      $display("FAIL rd_re_cycles: got %0d exp 3", n_re);
    end
    vectors++;
    if (spi_tx_d !== 8'hA5 || spi_tx_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_load: got tx_d=%h tx_en=%b exp tx_d=a5 tx_en=1", spi_tx_d, spi_tx_en);
    end
    n_en = 0;
    for (int i = 0; i < 6; i++) begin
      if (spi_tx_en) n_en++;
      tick();
    end
    vectors++;
    if (n_en != 2) begin
      miscompares++;
      $display("FAIL rd_txen_cycles: got %0d exp 2", n_en);
    end
    vectors++;
    if (busy !== 1'b0 || spi_tx_d !== 8'hA5) begin
      miscompares++;
      $display("FAIL rd_done: got busy=%b tx_d=%h exp busy=0 tx_d=a5", busy, spi_tx_d);
    end
  endtask

  task automatic test_write();
    spi_addr_dv = 1'b1; spi_rw = 1'b1; spi_reg_addr = 7'h22;
    tick();
    spi_addr_dv = 1'b0; spi_rw = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b1 || bus_we !== 1'b0 || bus_re !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_wait: got busy=%b we=%b re=%b exp busy=1 we=0 re=0", busy, bus_we, bus_re);
    end
    spi_rxdv = 1'b1; spi_rx_d = 8'h3C;
    tick();
    vectors++;
    if (bus_we !== 1'b1 || bus_addr !== 7'h22 || bus_wdata !== 8'h3C) begin
      miscompares++;
      $display("FAIL wr_req: got we=%b addr=%h wdata=%h exp we=1 addr=22 wdata=3c", bus_we, bus_addr, bus_wdata);
    end
    repeat (2) tick();
    vectors++;
    if (bus_we !== 1'b1 || bus_re !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_hold: got we=%b re=%b exp we=1 re=0", bus_we, bus_re);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    vectors++;
    if (bus_we !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_done: got we=%b busy=%b exp we=0 busy=0", bus_we, busy);
    end
    repeat (3) tick();
    vectors++;
    if (bus_we !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_no_second: got we=%b busy=%b exp we=0 busy=0", bus_we, busy);
    end
    spi_rxdv = 1'b0;
    tick();
  endtask

  task automatic test_aborted_write();
    spi_addr_dv = 1'b1; spi_rw = 1'b1; spi_reg_addr = 7'h01;
    tick();
    spi_rw = 1'b0; spi_reg_addr = 7'h02;
    tick();
    spi_addr_dv = 1'b0;
    vectors++;
    if (bus_re !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 7'h02) begin
      miscompares++;
      $display("FAIL abort_restart: got re=%b we=%b addr=%h exp re=1 we=0 addr=02", bus_re, bus_we, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 8'h77;
    tick();
    bus_ack = 1'b0; bus_rdata = 8'h00;
    vectors++;
    if (spi_tx_d !== 8'h77 || bus_we !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_read: got tx_d=%h we=%b exp tx_d=77 we=0", spi_tx_d, bus_we);
    end
    repeat (3) tick();
  endtask

  task automatic test_ignored_events();
    // ack and rxdv rise while idle
    bus_ack = 1'b1; bus_rdata = 8'hFF; spi_rxdv = 1'b1; spi_rx_d = 8'h11;
    tick();
    bus_ack = 1'b0; bus_rdata = 8'h00;
    vectors++;
    if (busy !== 1'b0 || spi_tx_en !== 1'b0 || bus_we !== 1'b0 || spi_tx_d !== 8'h77) begin
      miscompares++;
      $display("FAIL idle_ignore: got busy=%b tx_en=%b we=%b tx_d=%h exp 0 0 0 77", busy, spi_tx_en, bus_we, spi_tx_d);
    end
    spi_rxdv = 1'b0;
    tick();
    // new address while a read is pending
    spi_addr_dv = 1'b1; spi_rw = 1'b0; spi_reg_addr = 7'h10;
    tick();
    spi_rw = 1'b1; spi_reg_addr = 7'h7F;
    tick();
    spi_addr_dv = 1'b0; spi_rw = 1'b0;
    vectors++;
    if (bus_addr !== 7'h10 || bus_re !== 1'b1 || bus_we !== 1'b0) begin
      miscompares++;
      $display("FAIL rdreq_ignore_addr: got addr=%h re=%b we=%b exp addr=10 re=1 we=0", bus_addr, bus_re, bus_we);
    end
    bus_ack = 1'b1; bus_rdata = 8'h42;
    tick();
    bus_ack = 1'b0; bus_rdata = 8'h00;
    vectors++;
    if (spi_tx_d !== 8'h42 || spi_tx_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_second: got tx_d=%h tx_en=%b exp 42 1", spi_tx_d, spi_tx_en);
    end
    repeat (3) tick();
  endtask

`ifdef SPI_BUS_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    spi_addr_dv = 1'b1; spi_rw = 1'b0; spi_reg_addr = 7'h30;
    tick();
    spi_addr_dv = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && bus_re; i++) begin n++; tick(); end
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL to_rd_cycles: got %0d exp 64", n);
    end
    vectors++;
    if (spi_tx_d !== 8'hEE || spi_tx_en !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL to_rd_result: got tx_d=%h tx_en=%b err=%b exp ee 1 1", spi_tx_d, spi_tx_en, err);
    end
    repeat (3) tick();
    err_clr = 1'b1;
    tick();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL to_err_clr: got %b exp 0", err);
    end
    // write timeout with err_clr held: set must win
    spi_addr_dv = 1'b1; spi_rw = 1'b1; spi_reg_addr = 7'h44;
    tick();
    spi_addr_dv = 1'b0; spi_rw = 1'b0; spi_rxdv = 1'b1; spi_rx_d = 8'h99;
    tick();
    n = 0;
    for (int i = 0; i < 100 && bus_we; i++) begin n++; tick(); end
    vectors++;
    if (n != 64 || err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL to_wr: got cycles=%0d err=%b busy=%b exp 64 1 0", n, err, busy);
    end
    err_clr = 1'b0; spi_rxdv = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    // ack in the very cycle the timeout would fire
    spi_addr_dv = 1'b1; spi_reg_addr = 7'h50;
    tick();
    spi_addr_dv = 1'b0;
    repeat (63) tick();
    bus_ack = 1'b1; bus_rdata = 8'h5A;
    tick();
    bus_ack = 1'b0; bus_rdata = 8'h00;
    vectors++;
    if (spi_tx_d !== 8'h5A || err !== 1'b0 || bus_re !== 1'b0) begin
      miscompares++;
      $display("FAIL to_ack_wins: got tx_d=%h err=%b re=%b exp 5a 0 0", spi_tx_d, err, bus_re);
    end
    repeat (3) tick();
  endtask
`else
  task automatic test_no_timeout();
    spi_addr_dv = 1'b1; spi_rw = 1'b0; spi_reg_addr = 7'h33;
    tick();
    spi_addr_dv = 1'b0;
    repeat (100) tick();
    vectors++;
    if (bus_re !== 1'b1 || busy !== 1'b1 || err !== 1'b0 || spi_tx_en !== 1'b0) begin
      miscompares++;
      $display("FAIL no_timeout: got re=%b busy=%b err=%b tx_en=%b exp 1 1 0 0", bus_re, busy, err, spi_tx_en);
    end
    bus_ack = 1'b1; bus_rdata = 8'h6B;
    tick();
    bus_ack = 1'b0; bus_rdata = 8'h00;
    vectors++;
    if (spi_tx_d !== 8'h6B || bus_re !== 1'b0) begin
      miscompares++;
      $display("FAIL no_timeout_ack: got tx_d=%h re=%b exp 6b 0", spi_tx_d, bus_re);
    end
    repeat (3) tick();
  endtask
`endif

  task automatic test_reset_mid_read();
    spi_addr_dv = 1'b1; spi_rw = 1'b0; spi_reg_addr = 7'h15;
    tick();
    spi_addr_dv = 1'b0;
    #2;
    reset_i = 1'b0;
    #1;
    vectors++;
    if (bus_re !== 1'b0 || busy !== 1'b0 || spi_tx_en !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got re=%b busy=%b tx_en=%b exp 0 0 0", bus_re, busy, spi_tx_en);
    end
    tick();
    reset_i = 1'b1;
    tick();
    spi_addr_dv = 1'b1; spi_reg_addr = 7'h15;
    tick();
    spi_addr_dv = 1'b0;
    vectors++;
    if (bus_re !== 1'b1 || bus_addr !== 7'h15) begin
      miscompares++;
      $display("FAIL post_reset_req: got re=%b addr=%h exp 1 15", bus_re, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 8'hC3;
    tick();
    bus_ack = 1'b0; bus_rdata = 8'h00;
    vectors++;
    if (spi_tx_d !== 8'hC3 || spi_tx_en !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_load: got tx_d=%h tx_en=%b exp c3 1", spi_tx_d, spi_tx_en);
    end
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b0 || spi_tx_en !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_done: got busy=%b tx_en=%b exp 0 0", busy, spi_tx_en);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_aborted_write();
    test_ignored_events();
`ifdef SPI_BUS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Sequencer between spi_slave and the internal register bus. Turns spi_slave address, data and strobe outputs into single bus transactions.
- Read frames: fetches bus data and loads it into the slave's transmit shifter before the payload phase.
- Write frames: issues a bus write once the payload byte has arrived.
- Bus handshake is req/ack, with optional timeout.

Parameters:
- ADDRSZ, 7, SPI register address width; must equal spi_slave addrsz.
- PAYLOAD, 8, data width; must equal spi_slave payload.
- TXEN_HOLD, 2, cycles spi_tx_en stays high; must be ≥2 so the slave's 2-flop edge detector sees it.
- TIMEOUT_CYCLES, 64, bus ack timeout (only with SPI_BUS_TIMEOUT_EN).
- RD_ERR_VAL, 8'hEE, data returned on a timed-out read.

Ports:
- clk  in  1  system clock
- reset_i  in  1  asynchronous active-low reset
- spi_reg_addr  in  ADDRSZ  from spi_slave reg_addr
- spi_addr_dv  in  1  one-cycle pulse; address complete
- spi_rw  in  1  1 = host write, 0 = host read
- spi_rx_d  in  PAYLOAD  write payload from spi_slave
- spi_rxdv  in  1  level; high from last payload bit until frame end
- spi_tx_d  out  PAYLOAD  read data to spi_slave tx_d
- spi_tx_en  out  1  load strobe to spi_slave tx_en
- bus_addr  out  ADDRSZ  register address
- bus_wdata  out  PAYLOAD  write data
- bus_we  out  1  write request, held until ack
- bus_re  out  1  read request, held until ack
- bus_rdata  in  PAYLOAD  read data, valid with ack
- bus_ack  in  1  one-cycle completion
- busy  out  1  high in any state except IDLE
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

Behaviour:
- Reset (reset_i low, asynchronous): state = IDLE; all outputs 0; rxdv edge register = 0.
- rxdv rise is detected internally as spi_rxdv = 1 with its previous-cycle value = 0.
- IDLE:
  - spi_addr_dv with spi_rw = 0: latch bus_addr = spi_reg_addr, assert bus_re next cycle, go to RD_REQ.
  - spi_addr_dv with spi_rw = 1: latch bus_addr, go to WR_WAIT.
- RD_REQ: hold bus_re.
  - On bus_ack: spi_tx_d <= bus_rdata, bus_re <= 0, spi_tx_en <= 1, go to RD_LOAD.
- RD_LOAD: hold spi_tx_en high for TXEN_HOLD cycles including the entry cycle, then drive it 0 and go to IDLE.
  - spi_tx_d holds its value until the next load.
- WR_WAIT: on rxdv rise, latch bus_wdata = spi_rx_d, assert bus_we, go to WR_REQ.
- WR_REQ: hold bus_we; on bus_ack, deassert and go to IDLE.
- Latency: addr_dv to bus_re is 1 cycle; bus_ack to spi_tx_en is 1 cycle; rxdv rise to bus_we is 1 cycle.
- Only one request is ever asserted; bus_re and bus_we are never high together.
- spi_addr_dv in WR_WAIT (aborted frame, new frame started): discard the pending write and restart from the IDLE decision in the same cycle.
- spi_addr_dv in RD_REQ, RD_LOAD or WR_REQ: ignored; the bus transaction always completes.
- rxdv rise in any state other than WR_WAIT: ignored.
- bus_ack in IDLE, WR_WAIT or RD_LOAD: ignored.
- err_clr clears err. If err_clr and a new timeout occur in the same cycle, set wins.
- Reset mid-transaction drops requests immediately. The bus slave must tolerate an abandoned request.

Optional Feature:
- Macro SPI_BUS_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on entry to RD_REQ or WR_REQ and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the request deasserts and err sets.
  - RD_REQ then loads spi_tx_d = RD_ERR_VAL and proceeds to RD_LOAD.
  - WR_REQ drops the write and goes to IDLE.
  - Ack arriving in the same cycle as timeout counts as success.
- When undefined: no counter; requests wait for ack indefinitely; err is tied 0.

Test Plan:
- Read: addr_dv with spi_rw = 0, addr 7'h15; ack after 3 cycles with rdata 8'hA5 -> bus_re high for 3 cycles; spi_tx_d = 8'hA5; spi_tx_en high exactly 2 cycles; busy drops after.
- Write: addr_dv with spi_rw = 1, addr 7'h22; then rxdv rises with rx_d 8'h3C -> bus_we with bus_addr 7'h22 and bus_wdata 8'h3C one cycle later; held until ack; rxdv still high afterwards -> no second write.
- Aborted write: addr_dv write to 7'h01, then addr_dv read to 7'h02 before rxdv -> no bus_we; bus_re to 7'h02.
- Timeout (SPI_BUS_TIMEOUT_EN): read with no ack -> bus_re drops after 64 cycles; spi_tx_d = 8'hEE; err = 1; err_clr -> err = 0. Repeat for write -> no data lost beyond the dropped write; err = 1.
- Reset mid RD_REQ: assert reset_i low -> bus_re, busy and spi_tx_en go to 0 asynchronously; after release, a read to 7'h15 completes normally.
- Ack and timeout coincide at cycle 64 with rdata 8'h5A -> spi_tx_d = 8'h5A; err stays 0.
